// File: rtl/tenthirty_ctrl.sv
// Ten-and-a-half game sequencer: requests cards from the deck, accumulates both hands in
// half-points, runs the dealer draw policy, scores each round and counts rounds to game end.
module tenthirty_ctrl #(
  parameter int unsigned MAX_CARDS    = 5,
  parameter int unsigned BUST_LIMIT   = 21,
  parameter int unsigned DEALER_STAND = 14,
  parameter int unsigned NUM_ROUNDS   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hit_p,
  input  logic       stand_p,
  input  logic [3:0] number,
  input  logic       empty,
  output logic       pip,
  output logic [5:0] player_pts,
  output logic [5:0] dealer_pts,
  output logic [3:0] last_card,
  output logic [2:0] p_cnt,
  output logic [2:0] d_cnt,
  output logic [2:0] round,
  output logic [2:0] led
);

  localparam logic [5:0] BustLim   = 6'(BUST_LIMIT);
  localparam logic [5:0] StandLim  = 6'(DEALER_STAND);
  localparam logic [2:0] MaxCnt    = 3'(MAX_CARDS);
  localparam logic [2:0] LastRound = 3'(NUM_ROUNDS);

  localparam logic [2:0] LedDealer = 3'b001;
  localparam logic [2:0] LedPlayer = 3'b010;
  localparam logic [2:0] LedDone   = 3'b100;

  typedef enum logic [3:0] {
    StIdle,
    StPReq,
    StPWait,
    StPChk,
    StPTurn,
    StDChk,
    StDReq,
    StDWait,
    StCmp,
    StShow,
    StDone
  } state_e;

  state_e state;

  // Face cards (11..13) are worth half a point; pips 1..10 are worth their face value.
  function automatic logic [5:0] card_val(input logic [3:0] n);
    if (n > 4'd10) return 6'd1;
    return {1'b0, n, 1'b0};
  endfunction

  function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [5:0] b);
    logic [6:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[6] ? 6'h3f : s[5:0];
  endfunction

  assign pip = (state == StPReq) || (state == StDReq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      player_pts <= '0;
      dealer_pts <= '0;
      last_card  <= '0;
      p_cnt      <= '0;
      d_cnt      <= '0;
      round      <= '0;
      led        <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (hit_p) begin
            round      <= 3'd1;
            player_pts <= '0;
            dealer_pts <= '0;
            p_cnt      <= '0;
            d_cnt      <= '0;
            if (empty) begin
              led   <= LedDone;
              state <= StDone;
            end else begin
              led   <= '0;
              state <= StPReq;
            end
          end
        end

        StPReq: state <= StPWait;

        StPWait: begin
          player_pts <= sat_add(player_pts, card_val(number));
          last_card  <= number;
          p_cnt      <= p_cnt + 3'd1;
          state      <= StPChk;
        end

        StPChk: begin
          if (player_pts > BustLim) begin
            led   <= LedDealer;
            state <= StShow;
          end else if (p_cnt == MaxCnt) begin
            led   <= LedPlayer;
            state <= StShow;
          end else begin
            state <= StPTurn;
          end
        end

        // Stand wins over a simultaneous hit.
        StPTurn: begin
          if (stand_p) begin
            state <= StDChk;
          end else if (hit_p) begin
            if (empty) begin
              led   <= LedDone;
              state <= StDone;
            end else begin
              state <= StPReq;
            end
          end
        end

        StDChk: begin
          if (dealer_pts > BustLim) begin
            led   <= LedPlayer;
            state <= StShow;
          end else if (d_cnt == MaxCnt) begin
            led   <= LedDealer;
            state <= StShow;
          end else if (dealer_pts < StandLim) begin
            if (empty) begin
              led   <= LedDone;
              state <= StDone;
            end else begin
              state <= StDReq;
            end
          end else begin
            state <= StCmp;
          end
        end

        StDReq: state <= StDWait;

        StDWait: begin
          dealer_pts <= sat_add(dealer_pts, card_val(number));
          last_card  <= number;
          d_cnt      <= d_cnt + 3'd1;
          state      <= StDChk;
        end

        // Ties go to the dealer.
        StCmp: begin
          led   <= (player_pts > dealer_pts) ? LedPlayer : LedDealer;
          state <= StShow;
        end

        StShow: begin
          if (hit_p) begin
            if (round < LastRound) begin
              round      <= round + 3'd1;
              player_pts <= '0;
              dealer_pts <= '0;
              p_cnt      <= '0;
              d_cnt      <= '0;
              if (empty) begin
                led   <= LedDone;
                state <= StDone;
              end else begin
                led   <= '0;
                state <= StPReq;
              end
            end else begin
              led   <= LedDone;
              state <= StDone;
            end
          end
        end

        StDone: led <= LedDone;

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tenthirty_ctrl.sv
// Directed bench for tenthirty_ctrl: plays a full four-round game with hand-computed scores,
// then covers simultaneous buttons, reset mid-deal and an exhausted deck.
module tb_tenthirty_ctrl;

  logic       clk;
  logic       rst_n;
  logic       hit_p;
  logic       stand_p;
  logic [3:0] number;
  logic       empty;
  logic       pip;
  logic [5:0] player_pts;
  logic [5:0] dealer_pts;
  logic [3:0] last_card;
  logic [2:0] p_cnt;
  logic [2:0] d_cnt;
  logic [2:0] round;
  logic [2:0] led;

  int total;
  int bad;
  int pip_cnt;

  tenthirty_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hit_p     (hit_p),
    .stand_p   (stand_p),
    .number    (number),
    .empty     (empty),
    .pip       (pip),
    .player_pts(player_pts),
    .dealer_pts(dealer_pts),
    .last_card (last_card),
    .p_cnt     (p_cnt),
    .d_cnt     (d_cnt),
    .round     (round),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (pip === 1'b1) pip_cnt++;

  task automatic press_hit();
    @(negedge clk) hit_p = 1'b1;
    @(negedge clk) hit_p = 1'b0;
  endtask

  task automatic press_stand();
    @(negedge clk) stand_p = 1'b1;
    @(negedge clk) stand_p = 1'b0;
  endtask

  // Acts as the deck: waits (bounded) for a pip and presents the card for the following cycle.
  task automatic feed(input logic [3:0] c);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pip === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL feed_timeout card=%0d: pip never seen, required a pip", c);
    end else begin
      number = c;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    hit_p   = 1'b0;
    stand_p = 1'b0;
    empty   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    hit_p   = 1'b0;
    stand_p = 1'b0;
    empty   = 1'b0;
    number  = 4'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({pip, player_pts, dealer_pts, last_card, p_cnt, d_cnt, round, led} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got pip=%b pp=%0d dp=%0d lc=%0d pc=%0d dc=%0d rd=%0d led=%b, required all 0",
               pip, player_pts, dealer_pts, last_card, p_cnt, d_cnt, round, led);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (pip !== 1'b0 || round !== 3'd0) begin
      bad++;
      $display("FAIL idle_quiet: got pip=%b round=%0d, required pip=0 round=0", pip, round);
    end
  endtask

  // Round 1: player 7 stands on 14; dealer 12,3,10 -> 1,7,27 busts.
  task automatic test_dealer_bust();
    int base;
    base = pip_cnt;
    press_hit();
    feed(4'd7);
    repeat (4) @(negedge clk);
    total++;
    if (player_pts !== 6'd14 || p_cnt !== 3'd1 || round !== 3'd1) begin
      bad++;
      $display("FAIL r1_player: got pp=%0d pc=%0d rd=%0d, required 14 1 1", player_pts, p_cnt, round);
    end
    press_stand();
    feed(4'd12);
    feed(4'd3);
    feed(4'd10);
    repeat (4) @(negedge clk);
    total++;
    if (dealer_pts !== 6'd27 || d_cnt !== 3'd3 || led !== 3'b010 || last_card !== 4'd10) begin
      bad++;
      $display("FAIL r1_dealer_bust: got dp=%0d dc=%0d led=%b lc=%0d, required 27 3 010 10",
               dealer_pts, d_cnt, led, last_card);
    end
    total++;
    if (pip_cnt - base != 4) begin
      bad++;
      $display("FAIL r1_pips: got %0d, required 4", pip_cnt - base);
    end
  endtask

  // Round 2: player 10 then 5 -> 30 busts, dealer never draws.
  task automatic test_player_bust();
    int base;
    base = pip_cnt;
    press_hit();
    feed(4'd10);
    repeat (4) @(negedge clk);
    press_hit();
    feed(4'd5);
    repeat (4) @(negedge clk);
    total++;
    if (player_pts !== 6'd30 || led !== 3'b001 || d_cnt !== 3'd0 || dealer_pts !== 6'd0 ||
        round !== 3'd2) begin
      bad++;
      $display("FAIL r2_player_bust: got pp=%0d led=%b dc=%0d dp=%0d rd=%0d, required 30 001 0 0 2",
               player_pts, led, d_cnt, dealer_pts, round);
    end
    total++;
    if (pip_cnt - base != 2) begin
      bad++;
      $display("FAIL r2_pips: got %0d, required 2", pip_cnt - base);
    end
  endtask

  // Round 3: five face cards -> 5 half-points, five-card win without standing.
  task automatic test_five_cards();
    logic [3:0] cards [5];
    cards = '{4'd11, 4'd12, 4'd13, 4'd11, 4'd12};
    press_hit();
    feed(cards[0]);
    for (int i = 1; i < 5; i++) begin
      repeat (4) @(negedge clk);
      press_hit();
      feed(cards[i]);
    end
    repeat (4) @(negedge clk);
    total++;
    if (player_pts !== 6'd5 || p_cnt !== 3'd5 || led !== 3'b010 || d_cnt !== 3'd0) begin
      bad++;
      $display("FAIL r3_five_cards: got pp=%0d pc=%0d led=%b dc=%0d, required 5 5 010 0",
               player_pts, p_cnt, led, d_cnt);
    end
  endtask

  // Round 4: player 14, dealer 4,3 -> 14; tie goes to the dealer.
  task automatic test_tie();
    int base;
    base = pip_cnt;
    press_hit();
    feed(4'd7);
    repeat (4) @(negedge clk);
    press_stand();
    feed(4'd4);
    feed(4'd3);
    repeat (4) @(negedge clk);
    total++;
    if (dealer_pts !== 6'd14 || player_pts !== 6'd14 || d_cnt !== 3'd2 || led !== 3'b001 ||
        round !== 3'd4) begin
      bad++;
      $display("FAIL r4_tie: got dp=%0d pp=%0d dc=%0d led=%b rd=%0d, required 14 14 2 001 4",
               dealer_pts, player_pts, d_cnt, led, round);
    end
    total++;
    if (pip_cnt - base != 3) begin
      bad++;
      $display("FAIL r4_pips: got %0d, required 3", pip_cnt - base);
    end
  endtask

  task automatic test_game_done();
    int base;
    press_hit();
    repeat (2) @(negedge clk);
    total++;
    if (led !== 3'b100 || round !== 3'd4) begin
      bad++;
      $display("FAIL done_entry: got led=%b round=%0d, required 100 4", led, round);
    end
    base = pip_cnt;
    press_hit();
    press_stand();
    press_hit();
    repeat (4) @(negedge clk);
    total++;
    if (pip_cnt != base || led !== 3'b100) begin
      bad++;
      $display("FAIL done_absorbing: got pips=%0d led=%b, required 0 100", pip_cnt - base, led);
    end
  endtask

  task automatic test_simultaneous();
    int base;
    do_reset();
    base = pip_cnt;
    press_hit();
    feed(4'd7);
    repeat (4) @(negedge clk);
    @(negedge clk);
    hit_p   = 1'b1;
    stand_p = 1'b1;
    @(negedge clk);
    hit_p   = 1'b0;
    stand_p = 1'b0;
    feed(4'd10);
    repeat (4) @(negedge clk);
    total++;
    if (p_cnt !== 3'd1 || d_cnt !== 3'd1 || dealer_pts !== 6'd20 || led !== 3'b001 ||
        pip_cnt - base != 2) begin
      bad++;
      $display("FAIL hit_stand_same_cycle: got pc=%0d dc=%0d dp=%0d led=%b pips=%0d, required 1 1 20 001 2",
               p_cnt, d_cnt, dealer_pts, led, pip_cnt - base);
    end
  endtask

  task automatic test_reset_mid_deal();
    int base;
    press_hit();
    feed(4'd5);
    repeat (4) @(negedge clk);
    press_stand();
    feed(4'd9);
    // Now in the dealer's wait cycle.
    rst_n = 1'b0;
    #1;
    total++;
    if ({pip, player_pts, dealer_pts, last_card, p_cnt, d_cnt, round, led} !== '0) begin
      bad++;
      $display("FAIL reset_mid_deal: got pip=%b pp=%0d dp=%0d lc=%0d pc=%0d dc=%0d rd=%0d led=%b, required all 0",
               pip, player_pts, dealer_pts, last_card, p_cnt, d_cnt, round, led);
    end
    @(negedge clk) rst_n = 1'b1;
    base = pip_cnt;
    press_stand();
    repeat (3) @(negedge clk);
    total++;
    if (pip_cnt != base || round !== 3'd0) begin
      bad++;
      $display("FAIL post_reset_idle: got pips=%0d round=%0d, required 0 0", pip_cnt - base, round);
    end
    press_hit();
    total++;
    if (pip !== 1'b1 || round !== 3'd1) begin
      bad++;
      $display("FAIL post_reset_start: got pip=%b round=%0d, required 1 1", pip, round);
    end
  endtask

  task automatic test_empty();
    int base;
    do_reset();
    base  = pip_cnt;
    empty = 1'b1;
    press_hit();
    repeat (3) @(negedge clk);
    total++;
    if (led !== 3'b100 || pip_cnt != base || p_cnt !== 3'd0) begin
      bad++;
      $display("FAIL empty_at_start: got led=%b pips=%0d pc=%0d, required 100 0 0",
               led, pip_cnt - base, p_cnt);
    end
    do_reset();
    base = pip_cnt;
    press_hit();
    feed(4'd7);
    repeat (4) @(negedge clk);
    empty = 1'b1;
    press_stand();
    repeat (4) @(negedge clk);
    total++;
    if (led !== 3'b100 || d_cnt !== 3'd0 || player_pts !== 6'd14 || pip_cnt - base != 1) begin
      bad++;
      $display("FAIL empty_at_dealer: got led=%b dc=%0d pp=%0d pips=%0d, required 100 0 14 1",
               led, d_cnt, player_pts, pip_cnt - base);
    end
    empty = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    pip_cnt = 0;
    test_reset();
    test_dealer_bust();
    test_player_bust();
    test_five_cards();
    test_tie();
    test_game_done();
    test_simultaneous();
    test_reset_mid_deal();
    test_empty();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
